// File: rtl/fsm_input_conditioner.sv
// Two-button front end: per channel a 2-FF synchronizer, a counted debounce
// state machine and a rising-edge one-shot feeding the downstream FSM.

module fsm_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btnA,
    input  logic btnB,
    output logic pulseA,
    output logic pulseB,
    output logic levelA,
    output logic levelB
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk  (clk),
        .rst_n(reset),
        .raw  (btnA),
        .pulse(pulseA),
        .level(levelA)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk  (clk),
        .rst_n(reset),
        .raw  (btnB),
        .pulse(pulseB),
        .level(levelB)
    );

endmodule

// One independent channel: synchronize, qualify N consecutive samples, emit
// a single-cycle pulse only when a press is accepted.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        CHK_HI    = 2'd1,
        HI_STABLE = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= LO_STABLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // one-shot: only the accepting transition below re-asserts it
            pulse <= 1'b0;
            case (state)
                LO_STABLE: begin
                    level <= 1'b0;
                    if (sync2) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!sync2) begin
                        state <= LO_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HI_STABLE;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HI_STABLE: begin
                    level <= 1'b1;
                    if (!sync2) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (sync2) begin
                        state <= HI_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LO_STABLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= LO_STABLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench for fsm_input_conditioner with N=4: stimulus queues the
// expected output transitions, a negedge monitor matches what the DUT does.

module tb_fsm_input_conditioner;

    localparam int unsigned N   = 4;
    localparam int          LAT = 6;

    logic clk;
    logic reset;
    logic btnA;
    logic btnB;
    logic pulseA;
    logic pulseB;
    logic levelA;
    logic levelB;

    fsm_input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btnA  (btnA),
        .btnB  (btnB),
        .pulseA(pulseA),
        .pulseB(pulseB),
        .levelA(levelA),
        .levelB(levelB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // signal ids: 0 pulseA, 1 pulseB, 2 levelA, 3 levelB
    typedef struct {
        int   sig;
        int   cyc;
        logic val;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string nm[4] = '{"pulseA", "pulseB", "levelA", "levelB"};

    task automatic exp_ev(input int s, input int c, input logic v);
        exp_t e;
        e.sig = s;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({pulseA, pulseB, levelA, levelB} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: outputs pA pB lA lB = %b%b%b%b, required 0000",
                     tag, pulseA, pulseB, levelA, levelB);
        end
    endtask

    // Monitor: every output transition must match the oldest expectation
    // queued for that signal; pulses must also drop after exactly one cycle.
    logic [3:0] prev = 4'b0000;
    logic [3:0] cur;
    int         rise_cyc[2] = '{0, 0};

    always @(negedge clk) begin
        cur = {levelB, levelA, pulseB, pulseA};
        for (int s = 0; s < 4; s++) begin
            if (cur[s] !== prev[s]) begin
                if (s < 2 && cur[s] !== 1'b1) begin
                    checks++;
                    if (edge_cnt != rise_cyc[s] + 1) begin
                        errors++;
                        $display("FAIL %s_width: fell at edge %0d, required %0d",
                                 nm[s], edge_cnt, rise_cyc[s] + 1);
                    end
                end else begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].sig == s) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL %s_unexpected: went %b at edge %0d, required no change",
                                 nm[s], cur[s], edge_cnt);
                    end else begin
                        if (sb[idx].cyc != edge_cnt || sb[idx].val !== cur[s]) begin
                            errors++;
                            $display("FAIL %s_event: got %b at edge %0d, required %b at edge %0d",
                                     nm[s], cur[s], edge_cnt, sb[idx].val, sb[idx].cyc);
                        end
                        sb.delete(idx);
                    end
                    if (s < 2) rise_cyc[s] = edge_cnt;
                end
            end
        end
        prev = cur;
    end

    int e0;

    initial begin
        reset = 1'b1;
        btnA  = 1'b0;
        btnB  = 1'b0;

        // 1. reset with both buttons held, then release with both still held
        #2 reset = 1'b0;
        btnA = 1'b1;
        btnB = 1'b1;
        #1 check_zero("reset_immediate");
        tick(3);
        check_zero("reset_held");
        reset = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
        exp_ev(1, e0 + LAT, 1'b1); exp_ev(3, e0 + LAT, 1'b1);
        tick(10);
        btnA = 1'b0;
        btnB = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0); exp_ev(3, e0 + LAT, 1'b0);
        tick(10);

        // 2. clean press held 20 cycles, then release
        btnA = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
        tick(20);
        btnA = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0);
        tick(10);

        // 3. bounce 3 high / 2 low / 3 high rejected, then a real press
        btnA = 1'b1; tick(3);
        btnA = 1'b0; tick(2);
        btnA = 1'b1; tick(3);
        btnA = 1'b0; tick(5);
        btnA = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
        tick(15);
        btnA = 1'b0; tick(3);
        btnA = 1'b1; tick(10);
        btnA = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0);
        tick(10);

        // 4. simultaneous presses, then B delayed by two cycles
        btnA = 1'b1;
        btnB = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
        exp_ev(1, e0 + LAT, 1'b1); exp_ev(3, e0 + LAT, 1'b1);
        tick(10);
        btnA = 1'b0;
        btnB = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0); exp_ev(3, e0 + LAT, 1'b0);
        tick(10);
        btnA = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1);     exp_ev(2, e0 + LAT, 1'b1);
        exp_ev(1, e0 + LAT + 2, 1'b1); exp_ev(3, e0 + LAT + 2, 1'b1);
        tick(2);
        btnB = 1'b1;
        tick(12);
        btnA = 1'b0;
        btnB = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0); exp_ev(3, e0 + LAT, 1'b0);
        tick(10);

        // 5. reset while CHK_HI counter sits at 2, button kept held
        btnA = 1'b1;
        e0 = edge_cnt + 1;
        tick(5);
        reset = 1'b0;
        #1 check_zero("reset_mid_qual");
        tick(3);
        check_zero("reset_mid_held");
        reset = 1'b1;
        e0 = edge_cnt + 1;
        exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
        tick(10);
        btnA = 1'b0;
        e0 = edge_cnt + 1;
        exp_ev(2, e0 + LAT, 1'b0);
        tick(10);

        // 6. five press/release rounds of 10 high + 10 low
        for (int r = 0; r < 5; r++) begin
            btnA = 1'b1;
            e0 = edge_cnt + 1;
            exp_ev(0, e0 + LAT, 1'b1); exp_ev(2, e0 + LAT, 1'b1);
            tick(10);
            btnA = 1'b0;
            e0 = edge_cnt + 1;
            exp_ev(2, e0 + LAT, 1'b0);
            tick(10);
        end

        tick(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected transitions never seen, required 0 (first: %s at edge %0d)",
                     sb.size(), nm[sb[0].sig], sb[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
